// File: rtl/llki_keyload_gen_if.sv
// LLKI discrete key-load handshake between the TSS side (master) and a core's key loader (slave).
interface llki_keyload_gen_if;
  logic [63:0] llkid_key_data;
  logic        llkid_key_valid;
  logic        llkid_key_ready;
  logic        llkid_key_complete;
  logic        llkid_clear_key;
  logic        llkid_clear_key_ack;

  modport master (
    output llkid_key_data, llkid_key_valid, llkid_clear_key,
    input  llkid_key_ready, llkid_key_complete, llkid_clear_key_ack
  );

  modport slave (
    input  llkid_key_data, llkid_key_valid, llkid_clear_key,
    output llkid_key_ready, llkid_key_complete, llkid_clear_key_ack
  );
endinterface

// File: rtl/llki_keyload_gen.sv
// Mock-TSS key loader: stores KEY_WORDS key words and exposes a registered obfuscation mask
// (all zero for the right key), with word-by-word wipe on clear, sticky overflow and status.
module llki_keyload_gen #(
  parameter int                        KEY_WORDS = 5,
  parameter logic [64*KEY_WORDS-1:0]   KEY_CONST = '0,
  parameter int                        CNT_W     = $clog2(KEY_WORDS+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  llki_keyload_gen_if.slave        llkid,
  output logic [64*KEY_WORDS-1:0]  mask_out,
  output logic                     key_unlocked,
  output logic                     key_overflow,
  output logic [CNT_W-1:0]         key_words_loaded
);

  localparam int               IDX_W    = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WORDS-1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(KEY_WORDS);

  typedef enum logic [1:0] {ST_LOAD, ST_COMPLETE, ST_CLEAR, ST_ACK} state_t;

  state_t                     state;
  logic [KEY_WORDS-1:0][63:0] key_reg;
  logic [IDX_W-1:0]           idx;
  logic                       clear_q;
  logic                       ready_q;
  logic                       complete_q;
  logic                       ack_q;
  logic                       clear_rise;
  logic                       accept;

  assign llkid.llkid_key_ready     = ready_q;
  assign llkid.llkid_key_complete  = complete_q;
  assign llkid.llkid_clear_key_ack = ack_q;

  assign clear_rise = llkid.llkid_clear_key & ~clear_q;
  assign accept     = llkid.llkid_key_valid & ready_q;

  // Clear edges are only honoured while loading or loaded, so a wipe in progress runs to its ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_LOAD;
      key_reg          <= '0;
      idx              <= '0;
      clear_q          <= 1'b0;
      ready_q          <= 1'b0;
      complete_q       <= 1'b0;
      ack_q            <= 1'b0;
      key_overflow     <= 1'b0;
      key_unlocked     <= 1'b0;
      key_words_loaded <= '0;
      mask_out         <= KEY_CONST;
    end else begin
      clear_q      <= llkid.llkid_clear_key;
      mask_out     <= key_reg ^ KEY_CONST;
      key_unlocked <= (state == ST_COMPLETE) && (key_reg == KEY_CONST);
      ack_q        <= 1'b0;
      if (clear_rise && (state == ST_LOAD || state == ST_COMPLETE)) begin
        state        <= ST_CLEAR;
        complete_q   <= 1'b0;
        ready_q      <= 1'b0;
        key_unlocked <= 1'b0;
        idx          <= '0;
      end else begin
        unique case (state)
          ST_LOAD: begin
            ready_q <= 1'b1;
            if (accept) begin
              key_reg[idx] <= llkid.llkid_key_data;
              if (key_words_loaded != FULL_CNT) begin
                key_words_loaded <= key_words_loaded + CNT_W'(1);
              end
              if (idx == LAST_IDX) begin
                state      <= ST_COMPLETE;
                ready_q    <= 1'b0;
                complete_q <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          ST_COMPLETE: begin
            ready_q    <= 1'b0;
            complete_q <= 1'b1;
            if (llkid.llkid_key_valid) begin
              key_overflow <= 1'b1;
            end
          end
          ST_CLEAR: begin
            key_reg[idx] <= '0;
            if (idx == LAST_IDX) begin
              // Ack and the status reset become visible together in the single ST_ACK cycle.
              state            <= ST_ACK;
              idx              <= '0;
              ack_q            <= 1'b1;
              key_overflow     <= 1'b0;
              key_words_loaded <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          ST_ACK: begin
            state   <= ST_LOAD;
            ready_q <= 1'b1;
            idx     <= '0;
          end
          default: begin
            state <= ST_LOAD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_llki_keyload_gen.sv
// Randomised scoreboard bench for llki_keyload_gen: stimulus pushes expected completion/ack
// events into a queue and an independent monitor pops and compares them when the DUT signals.
`timescale 1ns/1ps
module tb_llki_keyload_gen;

  localparam int KW = 5;
  localparam int CW = $clog2(KW+1);
  localparam logic [64*KW-1:0] KCONST = {64'h5A5A0F0F3C3C9696, 64'hC0FFEE0012345678,
                                         64'h0BADF00DDEADBEEF, 64'h0123456789ABCDEF,
                                         64'hA5A5A5A5A5A5A5A5};

  typedef enum {EV_COMPLETE, EV_ACK} ev_kind_t;
  typedef struct {
    ev_kind_t          kind;
    logic [64*KW-1:0]  mask;
    bit                unlocked;
    int                loaded;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [64*KW-1:0]  mask_out;
  logic              key_unlocked;
  logic              key_overflow;
  logic [CW-1:0]     key_words_loaded;

  logic [63:0]       model_key [KW];
  int                model_cnt;
  bit                model_complete;
  ev_t               exp_q [$];
  int                tests = 0;
  int                fails = 0;

  llki_keyload_gen_if kif ();

  llki_keyload_gen #(
    .KEY_WORDS (KW),
    .KEY_CONST (KCONST),
    .CNT_W     (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .llkid            (kif.slave),
    .mask_out         (mask_out),
    .key_unlocked     (key_unlocked),
    .key_overflow     (key_overflow),
    .key_words_loaded (key_words_loaded)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] const_word(input int w);
    logic [64*KW-1:0] k = KCONST;
    return k[64*w +: 64];
  endfunction

  // The mask the loaded key should produce: each stored word XOR its constant word.
  function automatic logic [64*KW-1:0] model_mask();
    logic [64*KW-1:0] m = '0;
    for (int w = 0; w < KW; w++) m[64*w +: 64] = model_key[w] ^ const_word(w);
    return m;
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < KW; w++) model_key[w] = '0;
    model_cnt      = 0;
    model_complete = 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [64*KW-1:0] act,
                             input logic [64*KW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Offers one word after `gap` idle cycles and returns at the negedge after it was accepted.
  task automatic applyStimulus(input logic [63:0] word, input int gap);
    int n = 0;
    repeat (gap) begin
      kif.llkid_key_valid = 1'b0;
      @(negedge clk);
    end
    kif.llkid_key_data  = word;
    kif.llkid_key_valid = 1'b1;
    model_key[model_cnt] = word;
    if (model_cnt == KW-1) begin
      exp_q.push_back('{kind: EV_COMPLETE, mask: model_mask(),
                        unlocked: (model_mask() == '0), loaded: KW});
    end
    while (!kif.llkid_key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!kif.llkid_key_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL ready_timeout: ready stayed %0b, expected 1", kif.llkid_key_ready);
      kif.llkid_key_valid = 1'b0;
      return;
    end
    model_cnt++;
    if (model_cnt == KW) model_complete = 1'b1;
    @(negedge clk);
    kif.llkid_key_valid = 1'b0;
  endtask

  // mode 0: random words, 1: the correct key, 2: zero / all-ones in words 0 and 1 then correct.
  task automatic load_key(input int mode, input int nwords, input int gap_max);
    logic [63:0] w;
    for (int i = 0; i < nwords; i++) begin
      if (mode == 1) w = const_word(model_cnt);
      else if (mode == 2) w = (model_cnt == 0) ? 64'h0 :
                              (model_cnt == 1) ? 64'hFFFFFFFFFFFFFFFF : const_word(model_cnt);
      else w = {$urandom, $urandom};
      applyStimulus(w, $urandom_range(0, gap_max));
    end
    checkOutput("words_loaded", key_words_loaded, model_cnt);
  endtask

  task automatic overflow_burst(input int cycles);
    logic [64*KW-1:0] held = model_mask();
    for (int c = 0; c < cycles; c++) begin
      kif.llkid_key_data  = 64'hDEAD;
      kif.llkid_key_valid = 1'b1;
      @(negedge clk);
      checkOutput("ovf_ready_low", kif.llkid_key_ready, 0);
      checkOutput("ovf_set", key_overflow, 1);
      checkOutput("ovf_mask_held", mask_out, held);
    end
    kif.llkid_key_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("ovf_sticky", key_overflow, 1);
    checkOutput("ovf_loaded_held", key_words_loaded, KW);
  endtask

  // Raises clear (optionally with a colliding word) and follows the wipe one word per cycle.
  task automatic do_clear(input bit with_valid);
    logic [64*KW-1:0] pre = model_mask();
    logic [64*KW-1:0] e;
    kif.llkid_clear_key = 1'b1;
    if (with_valid) begin
      kif.llkid_key_data  = {$urandom, $urandom};
      kif.llkid_key_valid = 1'b1;
    end
    exp_q.push_back('{kind: EV_ACK, mask: KCONST, unlocked: 1'b0, loaded: 0});
    @(negedge clk);
    kif.llkid_key_valid = 1'b0;
    checkOutput("clear_complete_drop", kif.llkid_key_complete, 0);
    checkOutput("clear_ready_drop", kif.llkid_key_ready, 0);
    checkOutput("clear_no_accept", key_words_loaded, model_cnt);
    for (int k = 1; k <= KW+1; k++) begin
      @(negedge clk);
      for (int w = 0; w < KW; w++) e[64*w +: 64] = (w < k-1) ? const_word(w) : pre[64*w +: 64];
      checkOutput("wipe_step", mask_out, e);
      if (k == KW) checkOutput("ack_on_cycle", kif.llkid_clear_key_ack, 1);
    end
    repeat (20) @(negedge clk);
    kif.llkid_clear_key = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  task automatic reset_mid_clear();
    kif.llkid_clear_key = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_mask", mask_out, KCONST);
    checkOutput("rst_ready", kif.llkid_key_ready, 0);
    checkOutput("rst_complete", kif.llkid_key_complete, 0);
    checkOutput("rst_ack", kif.llkid_clear_key_ack, 0);
    checkOutput("rst_overflow", key_overflow, 0);
    checkOutput("rst_unlocked", key_unlocked, 0);
    checkOutput("rst_loaded", key_words_loaded, 0);
    @(negedge clk);
    kif.llkid_clear_key = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checkOutput("rst_ready_before_clock", kif.llkid_key_ready, 0);
    @(negedge clk);
    checkOutput("rst_ready_after_clock", kif.llkid_key_ready, 1);
  endtask

  // Monitor: every complete rise or ack pulse must match the oldest queued expectation.
  initial begin : monitor
    bit  prev_c;
    ev_t ev;
    prev_c = 1'b0;
    forever begin
      @(negedge clk);
      if (kif.llkid_clear_key_ack === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_ACK) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_ack: got ack=1, expected no ack");
        end else begin
          ev = exp_q.pop_front();
          @(negedge clk);
          checkOutput("ack_width", kif.llkid_clear_key_ack, 0);
          checkOutput("ack_mask", mask_out, ev.mask);
          checkOutput("ack_overflow", key_overflow, 0);
          checkOutput("ack_loaded", key_words_loaded, ev.loaded);
          checkOutput("ack_ready", kif.llkid_key_ready, 1);
        end
      end else if (kif.llkid_key_complete === 1'b1 && !prev_c) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_COMPLETE) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_complete: got complete=1, expected 0");
        end else begin
          ev = exp_q.pop_front();
          checkOutput("unlock_not_early", key_unlocked, 0);
          @(negedge clk);
          checkOutput("complete_mask", mask_out, ev.mask);
          checkOutput("complete_unlocked", key_unlocked, ev.unlocked);
          checkOutput("complete_loaded", key_words_loaded, ev.loaded);
          checkOutput("complete_ready", kif.llkid_key_ready, 0);
        end
      end
      prev_c = (kif.llkid_key_complete === 1'b1);
    end
  end

  initial begin : stimulus
    int act;
    kif.llkid_key_data  = '0;
    kif.llkid_key_valid = 1'b0;
    kif.llkid_clear_key = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_mask", mask_out, KCONST);
    checkOutput("reset_ready", kif.llkid_key_ready, 0);
    checkOutput("reset_complete", kif.llkid_key_complete, 0);
    checkOutput("reset_unlocked", key_unlocked, 0);
    checkOutput("reset_loaded", key_words_loaded, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_first_clock", kif.llkid_key_ready, 1);

    load_key(1, KW, 0);
    @(negedge clk);
    overflow_burst(3);
    do_clear(1'b0);

    load_key(2, KW, 0);
    @(negedge clk);
    checkOutput("wrong_key_mask", mask_out,
                {192'h0, 64'hFEDCBA9876543210, 64'hA5A5A5A5A5A5A5A5});
    checkOutput("wrong_key_locked", key_unlocked, 0);
    do_clear(1'b0);

    load_key(0, 1, 0);
    do_clear(1'b1);

    load_key(0, KW, 1);
    reset_mid_clear();
    load_key(1, KW, 0);
    @(negedge clk);
    do_clear(1'b0);

    for (int it = 0; it < 25; it++) begin
      act = $urandom_range(0, 3);
      if (act == 0) begin
        load_key(0, $urandom_range(1, KW-1), 2);
        do_clear($urandom_range(0, 1) == 1);
      end else begin
        load_key($urandom_range(0, 1), KW, 2);
        @(negedge clk);
        if (act == 1) overflow_burst($urandom_range(1, 3));
        do_clear($urandom_range(0, 1) == 1);
      end
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
